// File: rtl/dot_seq_ctrl.sv
// Dot-product sequencer driving one fma_4x4 into a signed ACC_W accumulator.
// Build option: define DOT_SAT_EN to clamp the accumulator on overflow (default wraps).

module fma_4x4 (
  input  logic signed [3:0] in_0,
  input  logic signed [3:0] in_1,
  input  logic signed [3:0] in_2,
  input  logic signed [3:0] in_3,
  input  logic signed [3:0] in_4,
  input  logic signed [3:0] in_5,
  input  logic signed [3:0] in_6,
  input  logic signed [3:0] in_7,
  output logic signed [9:0] out_0
);

  logic signed [7:0] p0, p1, p2, p3;

  // Each product spans -56..64, so four of them fit in 10 signed bits.
  always_comb begin
    p0    = 8'(in_0) * 8'(in_1);
    p1    = 8'(in_2) * 8'(in_3);
    p2    = 8'(in_4) * 8'(in_5);
    p3    = 8'(in_6) * 8'(in_7);
    out_0 = 10'(p0) + 10'(p1) + 10'(p2) + 10'(p3);
  end

endmodule

// state | meaning
// IDLE  | waiting for start; no beats taken, no result offered
// RUN   | taking operand beats until cnt reaches zero
// DONE  | result held on out_0 until out_ready
module dot_seq_ctrl #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [3:0]       in_0,
  input  logic signed [3:0]       in_1,
  input  logic signed [3:0]       in_2,
  input  logic signed [3:0]       in_3,
  input  logic signed [3:0]       in_4,
  input  logic signed [3:0]       in_5,
  input  logic signed [3:0]       in_6,
  input  logic signed [3:0]       in_7,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_0,
  output logic                    busy,
  output logic                    overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [LEN_W-1:0]        cnt;
  logic signed [9:0]       fma_sum;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum_raw;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    add_ovf;
  logic                    beat;

  fma_4x4 u_fma (
    .in_0  (in_0),
    .in_1  (in_1),
    .in_2  (in_2),
    .in_3  (in_3),
    .in_4  (in_4),
    .in_5  (in_5),
    .in_6  (in_6),
    .in_7  (in_7),
    .out_0 (fma_sum)
  );

  // in_ready is registered and high only in RUN, so it qualifies the beat directly.
  always_comb begin
    beat    = in_valid && in_ready;
    addend  = ACC_W'(fma_sum);
    sum_raw = acc + addend;
    add_ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef DOT_SAT_EN
    if (add_ovf) begin
      acc_nxt = addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_nxt = sum_raw;
    end
`else
    acc_nxt = sum_raw;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            overflow <= 1'b0;
            cnt      <= len;
            busy     <= 1'b1;
            if (len != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat) begin
            acc <= acc_nxt;
            cnt <= cnt - LEN_W'(1);
            if (add_ovf) overflow <= 1'b1;
            if (cnt == LEN_W'(1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_0 = acc;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Directed bench for dot_seq_ctrl: a 16-bit accumulator instance plus a 10-bit one for overflow.
module tb_dot_seq_ctrl;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              start10 = 1'b0;
  logic [7:0]        len = 8'd0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic signed [3:0] op [8];

  logic              in_ready, out_valid, busy, overflow;
  logic signed [15:0] out_0;
  logic              in_ready10, out_valid10, busy10, overflow10;
  logic signed [9:0] out10;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dot_seq_ctrl #(.ACC_W(16), .LEN_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_0(op[0]), .in_1(op[1]), .in_2(op[2]), .in_3(op[3]),
    .in_4(op[4]), .in_5(op[5]), .in_6(op[6]), .in_7(op[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_0(out_0),
    .busy(busy), .overflow(overflow)
  );

  dot_seq_ctrl #(.ACC_W(10), .LEN_W(8)) u_dut10 (
    .clk(clk), .rst(rst), .start(start10), .len(len),
    .in_valid(in_valid), .in_ready(in_ready10),
    .in_0(op[0]), .in_1(op[1]), .in_2(op[2]), .in_3(op[3]),
    .in_4(op[4]), .in_5(op[5]), .in_6(op[6]), .in_7(op[7]),
    .out_valid(out_valid10), .out_ready(out_ready), .out_0(out10),
    .busy(busy10), .overflow(overflow10)
  );

  task automatic set_all(input logic [3:0] v);
    for (int i = 0; i < 8; i++) op[i] = v;
  endtask

  // Pulse start on one instance, then hold in_valid for exactly n cycles.
  // Returns at the negedge where out_valid should first be high.
  task automatic drive_beats(input int n, input bit sel10);
    @(negedge clk);
    len = 8'(n);
    if (sel10) start10 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    start10 = 1'b0;
    in_valid = (n != 0);
    for (int i = 0; i < n; i++) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic accept;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid, busy, overflow} !== 4'b0000 || out_0 !== 16'sd0) begin
      $display("FAIL reset: rdy=%b vld=%b busy=%b ovf=%b out=%0d, want all 0",
               in_ready, out_valid, busy, overflow, out_0);
    end else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_len1;
    set_all(4'h1);
    @(negedge clk);
    len = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL len1_run: in_ready=%b busy=%b, want 1 1", in_ready, busy);
    end else pass_cnt++;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_0 !== 16'sd4 || overflow !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL len1_result: vld=%b out=%0d ovf=%b rdy=%b, want 1 4 0 0",
               out_valid, out_0, overflow, in_ready);
    end else pass_cnt++;
    accept();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL len1_accept: vld=%b busy=%b, want 0 0", out_valid, busy);
    end else pass_cnt++;
  endtask

  task automatic test_neg_stream;
    set_all(4'h8);
    drive_beats(3, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b1 || out_0 !== 16'sd768 || overflow !== 1'b0) begin
      $display("FAIL neg_stream: vld=%b out=%0d ovf=%b, want 1 768 0", out_valid, out_0, overflow);
    end else pass_cnt++;
    accept();
  endtask

  task automatic test_mixed;
    op[0] = 4'h7; op[1] = 4'h8; op[2] = 4'h8; op[3] = 4'h7;
    op[4] = 4'h3; op[5] = 4'h3; op[6] = 4'hF; op[7] = 4'hF;
    drive_beats(4, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b1 || out_0 !== -16'sd408) begin
      $display("FAIL mixed: vld=%b out=%0d, want 1 -408", out_valid, out_0);
    end else pass_cnt++;
    accept();
  endtask

  task automatic test_overflow;
    logic signed [9:0] exp10;
`ifdef DOT_SAT_EN
    exp10 = 10'h1FF;
`else
    exp10 = 10'h200;
`endif
    set_all(4'h8);
    drive_beats(2, 1'b1);
    total_cnt++;
    if (out_valid10 !== 1'b1 || out10 !== exp10 || overflow10 !== 1'b1) begin
      $display("FAIL overflow10: vld=%b out=%0d ovf=%b, want 1 %0d 1", out_valid10, out10, overflow10, exp10);
    end else pass_cnt++;
    accept();
    set_all(4'h1);
    drive_beats(1, 1'b1);
    total_cnt++;
    if (out_valid10 !== 1'b1 || out10 !== 10'sd4 || overflow10 !== 1'b0) begin
      $display("FAIL overflow_clear: vld=%b out=%0d ovf=%b, want 1 4 0", out_valid10, out10, overflow10);
    end else pass_cnt++;
    accept();
  endtask

  task automatic test_len0;
    set_all(4'h7);
    drive_beats(0, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b1 || out_0 !== 16'sd0 || in_ready !== 1'b0) begin
      $display("FAIL len0: vld=%b out=%0d rdy=%b, want 1 0 0", out_valid, out_0, in_ready);
    end else pass_cnt++;
    accept();
  endtask

  task automatic test_hold;
    set_all(4'h1);
    drive_beats(1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = 8'd2; in_valid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_0 !== 16'sd4 || in_ready !== 1'b0) begin
        $display("FAIL hold_%0d: vld=%b out=%0d rdy=%b, want 1 4 0", i, out_valid, out_0, in_ready);
      end else pass_cnt++;
    end
    start = 1'b0; in_valid = 1'b0;
    accept();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL hold_release: vld=%b busy=%b, want 0 0", out_valid, busy);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    set_all(4'h1);
    drive_beats(1, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1; len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL b2b_start: rdy=%b busy=%b, want 1 1", in_ready, busy);
    end else pass_cnt++;
    set_all(4'hF);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_0 !== 16'sd8) begin
      $display("FAIL b2b_result: vld=%b out=%0d, want 1 8", out_valid, out_0);
    end else pass_cnt++;
    accept();
  endtask

  task automatic test_reset_mid;
    int seen;
    set_all(4'h1);
    @(negedge clk);
    len = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, busy, overflow} !== 4'b0000 || out_0 !== 16'sd0) begin
      $display("FAIL reset_mid: rdy=%b vld=%b busy=%b ovf=%b out=%0d, want all 0",
               in_ready, out_valid, busy, overflow, out_0);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (seen != 0) begin
      $display("FAIL reset_mid_quiet: active cycles=%0d, want 0", seen);
    end else pass_cnt++;
    drive_beats(1, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b1 || out_0 !== 16'sd4) begin
      $display("FAIL reset_restart: vld=%b out=%0d, want 1 4", out_valid, out_0);
    end else pass_cnt++;
    accept();
  endtask

  initial begin
    set_all(4'h0);
    test_reset();
    test_len1();
    test_neg_stream();
    test_mixed();
    test_overflow();
    test_len0();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t, want finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
